// File: rtl/vram_wr_buffer.sv
// Posting FIFO between the HPS VRAM write bridge and the PPU write port.
// Queued writes are issued back to back inside the window opened by cpu_vram_wr_irq.
// Optional range check is enabled by the VRAM_WRBUF_RANGE_CHECK_EN macro.
module vram_wr_buffer #(
    parameter int          DEPTH         = 64,
    parameter logic [12:0] VRAM_MAX_ADDR = 13'h1A27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [12:0]              in_addr,
    input  logic [63:0]              in_data,
    input  logic [7:0]               in_byteena,
    input  logic                     cpu_vram_wr_irq,
    output logic                     cpu_wr_busy,
    output logic [12:0]              h2f_vram_wraddr,
    output logic                     h2f_vram_wren,
    output logic [63:0]              h2f_vram_wrdata,
    output logic [7:0]               h2f_vram_byteena,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [7:0]               dropped_cnt,
    output logic                     irq_overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    typedef struct packed {
        logic [12:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
    } entry_t;

    entry_t      r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [AW:0] r_remaining;
    logic [0:0]  r_state;
    logic        r_wren;
    logic        r_overrun;
    logic [12:0] r_wraddr;
    logic [63:0] r_wrdata;
    logic [7:0]  r_byteena;

    logic [AW:0] w_fill;
    logic        w_full;
    logic        w_in_range;
    logic        w_push;
    logic        w_start;
    logic        w_pop;

    assign w_fill   = r_wptr - r_rptr;
    assign w_full   = (w_fill == (AW+1)'(DEPTH));
    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready && w_in_range;
    // The first entry is popped on the irq edge itself so it appears the next cycle.
    assign w_start  = (r_state == S_IDLE) && cpu_vram_wr_irq && (w_fill != '0);
    assign w_pop    = w_start || (r_state == S_DRAIN);

    assign fill_level       = w_fill;
    assign cpu_wr_busy      = r_wren;
    assign h2f_vram_wren    = r_wren;
    assign h2f_vram_wraddr  = r_wraddr;
    assign h2f_vram_wrdata  = r_wrdata;
    assign h2f_vram_byteena = r_byteena;
    assign irq_overrun      = r_overrun;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= '{addr: in_addr, data: in_data, be: in_byteena};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_remaining <= '0;
            r_state     <= S_IDLE;
            r_wren      <= 1'b0;
            r_overrun   <= 1'b0;
            r_wraddr    <= '0;
            r_wrdata    <= '0;
            r_byteena   <= '0;
        end else begin
            r_wren <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_wraddr  <= r_mem[r_rptr[AW-1:0]].addr;
                r_wrdata  <= r_mem[r_rptr[AW-1:0]].data;
                r_byteena <= r_mem[r_rptr[AW-1:0]].be;
            end
            // r_remaining counts entries of the current window not yet popped.
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_remaining <= w_fill - 1'b1;
                        if (w_fill != (AW+1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                default: begin
                    if (cpu_vram_wr_irq) begin
                        r_overrun <= 1'b1;
                    end
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == (AW+1)'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef VRAM_WRBUF_RANGE_CHECK_EN
    logic [7:0] r_dropped;

    assign w_in_range  = (in_addr <= VRAM_MAX_ADDR);
    assign dropped_cnt = r_dropped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dropped <= '0;
        end else if (in_valid && in_ready && !w_in_range && (r_dropped != 8'hFF)) begin
            r_dropped <= r_dropped + 1'b1;
        end
    end
`else
    assign w_in_range  = 1'b1;
    assign dropped_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_wr_buffer.sv
// Randomized bench for vram_wr_buffer against a queue-based reference of the posting/window rules.
module tb_vram_wr_buffer;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_addr = '0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_byteena = '0;
    logic        cpu_vram_wr_irq = 1'b0;
    logic        cpu_wr_busy;
    logic [12:0] h2f_vram_wraddr;
    logic        h2f_vram_wren;
    logic [63:0] h2f_vram_wrdata;
    logic [7:0]  h2f_vram_byteena;
    logic [6:0]  fill_level;
    logic [7:0]  dropped_cnt;
    logic        irq_overrun;

    vram_wr_buffer #(.DEPTH(DEPTH), .VRAM_MAX_ADDR(13'h1A27)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_byteena(in_byteena),
        .cpu_vram_wr_irq(cpu_vram_wr_irq), .cpu_wr_busy(cpu_wr_busy),
        .h2f_vram_wraddr(h2f_vram_wraddr), .h2f_vram_wren(h2f_vram_wren),
        .h2f_vram_wrdata(h2f_vram_wrdata), .h2f_vram_byteena(h2f_vram_byteena),
        .fill_level(fill_level), .dropped_cnt(dropped_cnt), .irq_overrun(irq_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the FIFO is a queue; a window freezes its size at the irq edge.
    typedef struct {
        logic [12:0] a;
        logic [63:0] d;
        logic [7:0]  b;
    } ent_t;

    ent_t        mq[$];
    ent_t        cur;
    int          win_left = 0;
    int          pre_size;
    logic        e_wren = 1'b0;
    logic [12:0] e_addr = '0;
    logic [63:0] e_data = '0;
    logic [7:0]  e_be   = '0;
    logic        e_ovr  = 1'b0;
    int          e_drop = 0;
    int          n_issued = 0;

    function automatic logic addr_ok(input logic [12:0] a);
`ifdef VRAM_WRBUF_RANGE_CHECK_EN
        return a <= 13'h1A27;
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            win_left = 0;
            e_wren = 1'b0; e_addr = '0; e_data = '0; e_be = '0;
            e_ovr = 1'b0; e_drop = 0;
        end else begin
            pre_size = mq.size();
            e_wren = 1'b0;
            if (win_left > 0) begin
                if (cpu_vram_wr_irq) e_ovr = 1'b1;
                win_left = win_left - 1;
                cur = mq.pop_front();
                e_wren = 1'b1;
            end else if (cpu_vram_wr_irq && pre_size > 0) begin
                win_left = pre_size - 1;
                cur = mq.pop_front();
                e_wren = 1'b1;
            end
            if (e_wren) begin
                e_addr = cur.a; e_data = cur.d; e_be = cur.b;
                n_issued++;
            end
            if (in_valid && pre_size < DEPTH) begin
                if (addr_ok(in_addr)) mq.push_back('{a: in_addr, d: in_data, b: in_byteena});
                else if (e_drop < 255) e_drop++;
            end
        end
    end

    always @(negedge clk) begin
        chk("wren", h2f_vram_wren, e_wren);
        chk("busy", cpu_wr_busy, e_wren);
        chk("wraddr", h2f_vram_wraddr, e_addr);
        chk("wrdata", h2f_vram_wrdata, e_data);
        chk("byteena", h2f_vram_byteena, e_be);
        chk("fill", fill_level, mq.size());
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("overrun", irq_overrun, e_ovr);
        chk("dropped", dropped_cnt, e_drop);
    end

    task automatic drive(input logic v, input logic [12:0] a, input logic [63:0] d,
                         input logic [7:0] b, input logic irq);
        @(negedge clk);
        in_valid = v; in_addr = a; in_data = d; in_byteena = b; cpu_vram_wr_irq = irq;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 13'($urandom_range(0, 13'h1A27)), {$urandom, $urandom}, 8'($urandom), 1'b0);
    endtask

    logic [12:0] t1_addr [8];
    int          start_issued;

    initial begin
        t1_addr = '{13'h0000, 13'h07FF, 13'h0800, 13'h17FF, 13'h1800, 13'h19FF, 13'h1A00, 13'h1A27};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Region boundary addresses, in order.
        for (int i = 0; i < 8; i++) drive(1'b1, t1_addr[i], 64'd12345, 8'hFF, 1'b0);
        start_issued = n_issued;
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(12);
        chk("t1_count", n_issued - start_issued, 8);
        chk("t1_fill", fill_level, 0);

        // Fill to DEPTH, hold valid while full, then drain.
        push_rand(DEPTH);
        for (int i = 0; i < 3; i++) drive(1'b1, 13'h0123, 64'hDEAD, 8'h0F, 1'b0);
        chk("t2_full_ready", in_ready, 0);
        chk("t2_full_fill", fill_level, DEPTH);
        start_issued = n_issued;
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(1);
        chk("t2_ready_after_pop", in_ready, 1);
        idle(DEPTH + 4);
        chk("t2_count", n_issued - start_issued, DEPTH);

        // Pushes during a drain wait for the next window.
        push_rand(3);
        start_issued = n_issued;
        drive(1'b0, '0, '0, '0, 1'b1);
        push_rand(2);
        idle(4);
        chk("t3_count", n_issued - start_issued, 3);
        chk("t3_fill", fill_level, 2);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(4);
        chk("t3_fill2", fill_level, 0);

        // Overrun: second irq two cycles into a 10-entry drain.
        push_rand(10);
        start_issued = n_issued;
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(1);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(14);
        chk("t4_overrun", irq_overrun, 1);
        chk("t4_count", n_issued - start_issued, 10);

        // Out-of-range addresses and a zero byte-enable entry.
        drive(1'b1, 13'h1A28, 64'h1, 8'h00, 1'b0);
        drive(1'b1, 13'h1FFF, 64'h2, 8'h3C, 1'b0);
        idle(1);
`ifdef VRAM_WRBUF_RANGE_CHECK_EN
        chk("t5_fill", fill_level, 0);
        chk("t5_dropped", dropped_cnt, 2);
`else
        chk("t5_fill", fill_level, 2);
        chk("t5_dropped", dropped_cnt, 0);
`endif
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(4);

        // Asynchronous reset in the middle of a drain.
        push_rand(10);
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(4);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", cpu_wr_busy, 0);
        chk("t6_wren", h2f_vram_wren, 0);
        chk("t6_fill", fill_level, 0);
        chk("t6_overrun", irq_overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        start_issued = n_issued;
        drive(1'b0, '0, '0, '0, 1'b1);
        idle(4);
        chk("t6_no_writes", n_issued - start_issued, 0);

        // Random traffic with occasional windows and some out-of-range addresses.
        for (int i = 0; i < 600; i++)
            drive(1'($urandom_range(0, 3) != 0), 13'($urandom), {$urandom, $urandom},
                  8'($urandom), 1'($urandom_range(0, 19) == 0));
        idle(2);
        for (int w = 0; w < 3; w++) begin
            drive(1'b0, '0, '0, '0, 1'b1);
            idle(DEPTH + 2);
        end
        chk("final_fill", fill_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vram_wr_buffer.md
# vram_wr_buffer

Write-posting buffer between the HPS-to-FPGA VRAM write bridge and the PPU's `h2f_vram_*` write port. CPU writes are accepted at any time and queued. They are committed to VRAM only inside the PPU's write window, which opens on `cpu_vram_wr_irq`. While committing, `cpu_wr_busy` is held high so the PPU defers its own VRAM accesses.

## Interface
Parameters:
- `DEPTH`, 64: FIFO entries; power of two, 4..256.
- `VRAM_MAX_ADDR`, 13'h1A27: highest legal VRAM word address (end of sprite RAM).

Ports:
- `clk`  in  1: single clock domain (PPU clock).
- `rst`  in  1: reset, asynchronous, active-high.
- `in_valid`  in  1: CPU write request.
- `in_ready`  out  1: buffer can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_addr`  in  13: VRAM word address.
- `in_data`  in  64: write data.
- `in_byteena`  in  8: byte enables.
- `cpu_vram_wr_irq`  in  1: one-cycle pulse from the PPU; the write window is open.
- `cpu_wr_busy`  out  1: high while queued writes are being committed.
- `h2f_vram_wraddr`  out  13, `h2f_vram_wren`  out  1, `h2f_vram_wrdata`  out  64, `h2f_vram_byteena`  out  8: registered VRAM write port to the PPU.
- `fill_level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `dropped_cnt`  out  8: saturating count of discarded out-of-range writes.
- `irq_overrun`  out  1: sticky; a window opened while the buffer was still draining.

## Operation
- FIFO: register or MLAB array. Write pointer and read pointer each have one extra wrap bit.
  - `fill_level = wptr - rptr`, computed modulo 2^(log2 DEPTH + 1).
  - Full when `fill_level == DEPTH`.
- `in_ready = !full`. It is independent of FSM state, so pushes are accepted during a drain.
- Range check (see Configuration): an accepted write with `in_addr > VRAM_MAX_ADDR` completes its handshake but is not enqueued. `dropped_cnt` increments, saturating at 255.
- FSM, two states:
  - IDLE → DRAIN when `cpu_vram_wr_irq` is high and `fill_level != 0`. `remaining` loads with `fill_level` as sampled at that edge.
  - An irq with an empty FIFO: stay in IDLE; no busy, no writes.
  - DRAIN: every cycle pop the head, drive it on the `h2f_vram_*` registers with wren=1, and decrement `remaining`.
  - DRAIN → IDLE on the edge that pops the entry with `remaining == 1`.
- Entries pushed after the irq edge are not drained in this window; they wait for the next irq.
- irq while in DRAIN: ignored; sets `irq_overrun`. Only `rst` clears it.
- Simultaneous push and pop in the same cycle: both occur; `fill_level` is unchanged.
- Drain order is strict FIFO.
- `in_byteena == 0` entries are queued and issued like any other.

## Timing
- Reset values: `in_ready=1`, `cpu_wr_busy=0`, `h2f_vram_wren=0`, `h2f_vram_wraddr=0`, `h2f_vram_wrdata=0`, `h2f_vram_byteena=0`, `fill_level=0`, `dropped_cnt=0`, `irq_overrun=0`, FSM=IDLE, pointers=0.
- Let irq be sampled at edge k with N entries queued. Then entry i (0..N-1) is presented with wren=1 in the cycle after edge k+i.
- `cpu_wr_busy` is high in exactly the cycles where wren is high. It falls, together with wren, after edge k+N.
- Write-port outputs hold their last values when wren=0; only wren is guaranteed low.
- Push latency: an entry accepted at edge j is countable by `fill_level` after edge j, and is eligible for an irq sampled at edge j+1 or later.
- `rst` asserted mid-drain: all state returns to reset values immediately (asynchronously). Queued entries are lost.

## Configuration
- `VRAM_WRBUF_RANGE_CHECK_EN` defined: range check active; `dropped_cnt` counts as described.
- Not defined: every accepted write is enqueued regardless of address; `dropped_cnt` is tied to 0.

## Test plan
- Push 8 writes: addresses 0x0000, 0x07FF, 0x0800, 0x17FF, 0x1800, 0x19FF, 0x1A00, 0x1A27; data 12345; byteena 0xFF. Then pulse irq → 8 consecutive wren cycles in the same order, busy high for exactly those 8 cycles, `fill_level` returns to 0.
- Fill to DEPTH with irq never asserted → `in_ready=0` at `fill_level=64`; held `in_valid` is not accepted. Pulse irq → 64 writes; `in_ready` returns to 1 after the first pop.
- Queue 3 writes, pulse irq, push 2 more during the drain → exactly 3 writes in this window, `fill_level=2` afterwards. Next irq → the 2 remaining writes.
- Second irq 2 cycles into a 10-entry drain → `irq_overrun=1`; the drain still issues exactly 10 writes.
- With `VRAM_WRBUF_RANGE_CHECK_EN` defined, push to 0x1A28 and 0x1FFF → both handshakes complete, `fill_level` stays 0, `dropped_cnt=2`. Without the macro → `fill_level=2`, and both addresses are issued on the next irq.
- Assert `rst` for one cycle at drain entry 4 of 10 → busy, wren and `fill_level` are 0 immediately. A later irq produces no writes.
